pc_redirect_ctrl: RTL and testbench

- Producer side of the fetch-stage PC select path: resolves branches and jumps arriving from EX and drives the redirect target (`PCnew`) and select (`PCsel`) into the fetch PC mux.
- Sequences pipeline flushes after each taken redirect.
- Holds a pending redirect while fetch is stalled.
- Keeps saturating branch/taken statistics counters.
- Sits between the EX stage and IF, alongside the hazard unit.

---
 rtl/pc_redirect_ctrl_pkg.sv | 17 +
 rtl/pc_redirect_ctrl_branch_target_calc.sv | 41 ++++
 rtl/pc_redirect_ctrl.sv | 152 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_pkg
// Shared definitions for the PC redirect path:
//   - state_e : redirect FSM state encodings
//   - PC_INC  : sequential fetch increment (bytes per instruction)
// ---------------------------------------------------------------------------
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_redirect_ctrl_branch_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Purely combinational redirect target generator. Kept separate so the
// same block can be instantiated for early branch resolution in ID.
//
// Ports:
//   ex_pc      in  32  PC of the resolving instruction
//   ex_imm     in  32  sign-extended branch word offset
//   ex_jtarget in  26  jump word-index field
//   ex_jump    in  1   select jump target instead of branch target
//   target     out 32  redirect target
// ---------------------------------------------------------------------------
module branch_target_calc
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_jtarget,
  input  logic        ex_jump,
  output logic [31:0] target
);

  logic        [31:0] pc4;
  logic signed [31:0] imm_s;
  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  always_comb begin
    pc4       = ex_pc + PC_INC;
    imm_s     = ex_imm;
    // Word offset to byte offset; arithmetic shift keeps the sign and the
    // sum wraps modulo 2^32, so backward branches below 0 wrap silently.
    br_off    = imm_s <<< 2;
    br_target = pc4 + br_off;
    // Jumps stay inside the 256 MB region of the delay-slot PC.
    j_target  = {pc4[31:28], ex_jtarget, 2'b00};
    target    = ex_jump ? j_target : br_target;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
// Resolves branches/jumps from EX, drives the fetch PC mux (PCnew/PCsel),
// sequences the IF/ID and ID/EX flushes after a taken redirect, holds the
// redirect while fetch is stalled and keeps saturating branch statistics.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ex_valid              EX holds a valid instruction
//   ex_branch, ex_bne     conditional branch, sense (1 = BNE, 0 = BEQ)
//   ex_jump               unconditional jump (wins over ex_branch)
//   ex_zero               ALU zero flag
//   ex_pc, ex_imm         instruction PC, sign-extended word offset
//   ex_jtarget            jump word-index field
//   if_stall              fetch cannot accept a new PC this cycle
//   clr_cnt               synchronous clear of both counters
//   PCnew, PCsel          registered redirect target / select
//   flush_ifid,flush_idex registered pipeline squashes
//   branch_cnt, taken_cnt saturating statistics counters
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_bne,
  input  logic             ex_jump,
  input  logic             ex_zero,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [25:0]      ex_jtarget,
  input  logic             if_stall,
  input  logic             clr_cnt,
  output logic [31:0]      PCnew,
  output logic             PCsel,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  state_e      state_q;
  state_e      state_d;
  logic        taken;
  logic        resolved;
  logic        sample_ex;
  logic [31:0] target;
  logic        pcsel_d;
  logic        flush_ifid_d;
  logic        flush_idex_d;

  branch_target_calc u_target (
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_jtarget (ex_jtarget),
    .ex_jump    (ex_jump),
    .target     (target)
  );

  // EX contents are only trusted in IDLE; during REDIRECT/SQUASH the
  // instruction in EX is on the wrong path.
  always_comb begin
    sample_ex = (state_q == ST_IDLE);
    taken     = ex_valid & ((ex_branch & (ex_zero ^ ex_bne)) | ex_jump);
    resolved  = ex_valid & (ex_branch | ex_jump);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = taken ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: state_d = if_stall ? ST_REDIRECT : ST_SQUASH;
      ST_SQUASH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state, so the flops below present the
  // outputs for the state being entered (registered, glitch-free).
  always_comb begin
    pcsel_d      = 1'b0;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    case (state_d)
      ST_REDIRECT: begin
        pcsel_d      = 1'b1;
        flush_ifid_d = 1'b1;
        flush_idex_d = 1'b1;
      end
      ST_SQUASH: flush_idex_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCsel      <= 1'b0;
      flush_ifid <= 1'b0;
      flush_idex <= 1'b0;
      PCnew      <= 32'h0000_0000;
    end else begin
      PCsel      <= pcsel_d;
      flush_ifid <= flush_ifid_d;
      flush_idex <= flush_idex_d;
      // Target is captured once on entry and held until the redirect is
      // accepted, so fetch sees a stable PCnew for the whole PCsel pulse.
      if (sample_ex && taken) begin
        PCnew <= target;
      end
    end
  end

  // Statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (clr_cnt) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (sample_ex) begin
      if (resolved) begin
        branch_cnt <= sat_inc(branch_cnt);
      end
      if (taken) begin
        taken_cnt <= sat_inc(taken_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_bne;
  logic        ex_jump;
  logic        ex_zero;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic        if_stall;
  logic        clr_cnt;
  logic [31:0] PCnew;
  logic        PCsel;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] branch_cnt;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_bne     (ex_bne),
    .ex_jump    (ex_jump),
    .ex_zero    (ex_zero),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_jtarget (ex_jtarget),
    .if_stall   (if_stall),
    .clr_cnt    (clr_cnt),
    .PCnew      (PCnew),
    .PCsel      (PCsel),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic sel, input logic fi, input logic fx);
    chk({tag, ".PCsel"}, {31'd0, PCsel}, {31'd0, sel});
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fx});
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_bne = 1'b0; ex_jump = 1'b0;
    ex_zero = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0; ex_jtarget = 26'h0;
  endtask

  task automatic set_branch(input logic [31:0] pc, input logic [31:0] imm,
                            input logic zero, input logic bne);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0;
    ex_pc = pc; ex_imm = imm; ex_zero = zero; ex_bne = bne;
  endtask

  initial begin
    rst = 1'b1; if_stall = 1'b0; clr_cnt = 1'b0;
    idle_inputs();
    #12;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.PCnew", PCnew, 32'h0);
    chk("reset.branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("reset.taken_cnt", {16'd0, taken_cnt}, 32'd0);
    #3 rst = 1'b0;
    step();

    // BEQ taken: 0x100 + 4 + (3<<2) = 0x110
    set_branch(32'h0000_0100, 32'd3, 1'b1, 1'b0);
    step();
    idle_inputs();
    chk_ctl("beq.redirect", 1'b1, 1'b1, 1'b1);
    chk("beq.PCnew", PCnew, 32'h0000_0110);
    step();
    chk_ctl("beq.squash", 1'b0, 1'b0, 1'b1);
    step();
    chk_ctl("beq.idle", 1'b0, 1'b0, 1'b0);
    chk("beq.taken_cnt", {16'd0, taken_cnt}, 32'd1);
    chk("beq.branch_cnt", {16'd0, branch_cnt}, 32'd1);

    // Clear counters
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr.branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("clr.taken_cnt", {16'd0, taken_cnt}, 32'd0);

    // BNE not taken (zero=1)
    set_branch(32'h0000_0200, 32'd5, 1'b1, 1'b1);
    step();
    idle_inputs();
    chk_ctl("bne.nt", 1'b0, 1'b0, 1'b0);
    chk("bne.branch_cnt", {16'd0, branch_cnt}, 32'd1);
    chk("bne.taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("bne.PCnew_held", PCnew, 32'h0000_0110);

    // Jump: pc4 = 0xF000000C, {F, 0x40, 00} = 0xF0000100
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'hF000_0008; ex_jtarget = 26'h000_0040;
    step();
    idle_inputs();
    chk_ctl("jmp.redirect", 1'b1, 1'b1, 1'b1);
    chk("jmp.PCnew", PCnew, 32'hF000_0100);
    step();
    chk_ctl("jmp.squash", 1'b0, 1'b0, 1'b1);
    step();
    chk("jmp.branch_cnt", {16'd0, branch_cnt}, 32'd2);
    chk("jmp.taken_cnt", {16'd0, taken_cnt}, 32'd1);

    // Backward wrap: 0 + 4 + (-2<<2) = 0xFFFFFFFC, stalled 3 cycles
    set_branch(32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    chk_ctl("wrap.c1", 1'b1, 1'b1, 1'b1);
    chk("wrap.PCnew", PCnew, 32'hFFFF_FFFC);
    // Wrong-path taken branch held in EX during the stall
    set_branch(32'h0000_0400, 32'd1, 1'b1, 1'b0);
    if_stall = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_ctl($sformatf("wrap.c%0d", i), 1'b1, 1'b1, 1'b1);
      chk($sformatf("wrap.PCnew_c%0d", i), PCnew, 32'hFFFF_FFFC);
    end
    if_stall = 1'b0;
    step();
    chk_ctl("wrap.squash", 1'b0, 1'b0, 1'b1);
    idle_inputs();
    step();
    chk_ctl("wrap.idle", 1'b0, 1'b0, 1'b0);
    chk("wrap.branch_cnt", {16'd0, branch_cnt}, 32'd3);
    chk("wrap.taken_cnt", {16'd0, taken_cnt}, 32'd2);
    chk("wrap.PCnew_kept", PCnew, 32'hFFFF_FFFC);

    // Saturation: clear, then 65535 not-taken BEQs, then one more
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    set_branch(32'h0000_1000, 32'd1, 1'b0, 1'b0);
    repeat (65535) step();
    chk("sat.reach", {16'd0, branch_cnt}, 32'h0000_FFFF);
    step();
    chk("sat.hold", {16'd0, branch_cnt}, 32'h0000_FFFF);
    chk("sat.taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk_ctl("sat.idle", 1'b0, 1'b0, 1'b0);
    clr_cnt = 1'b1;
    step();
    chk("sat.clr_prio", {16'd0, branch_cnt}, 32'd0);
    clr_cnt = 1'b0;
    idle_inputs();
    step();

    // Reset asserted mid-REDIRECT
    set_branch(32'h0000_0300, 32'd2, 1'b1, 1'b0);
    step();
    idle_inputs();
    chk_ctl("rstmid.redirect", 1'b1, 1'b1, 1'b1);
    chk("rstmid.PCnew", PCnew, 32'h0000_030C);
    if_stall = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_ctl("rstmid.async", 1'b0, 1'b0, 1'b0);
    chk("rstmid.PCnew0", PCnew, 32'h0);
    #2 rst = 1'b0;
    if_stall = 1'b0;
    step();
    chk_ctl("rstmid.idle", 1'b0, 1'b0, 1'b0);
    set_branch(32'h0000_0100, 32'd3, 1'b1, 1'b0);
    step();
    idle_inputs();
    chk_ctl("rstmid.new", 1'b1, 1'b1, 1'b1);
    chk("rstmid.new_PCnew", PCnew, 32'h0000_0110);
    chk("rstmid.taken_cnt", {16'd0, taken_cnt}, 32'd1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
